// File: rtl/soc_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_mem_pkg
//  Description : Shared types, limits and round-robin pick helper for the
//                shared-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_mem_pkg;

   localparam int MAX_PORTS      = 8;
   localparam int MAX_DATA_WIDTH = 256;
   localparam int PTR_W          = $clog2(MAX_PORTS);
   localparam int PTR_W1         = PTR_W + 1;

   typedef struct packed {
      logic [MAX_PORTS-1:0]      port;
      logic [MAX_DATA_WIDTH-1:0] rdata;
      logic                      err;
   } rsp_stage_t;

   // Scan from ptr upward, wrapping at nports; first requester wins.
   function automatic logic [MAX_PORTS-1:0] rr_pick(
      input logic [MAX_PORTS-1:0] valid,
      input logic [PTR_W-1:0]     ptr,
      input logic [PTR_W1-1:0]    nports
   );
      logic [MAX_PORTS-1:0] grant;
      logic [PTR_W1-1:0]    idx;
      logic                 found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         idx = {1'b0, ptr} + PTR_W1'(i);
         if (idx >= nports) begin
            idx = idx - nports;
         end
         if (!found && (PTR_W1'(i) < nports) && valid[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage
`default_nettype wire

// File: rtl/soc_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : soc_mem_arbiter_if
//  Description : Multi-port request / shared response bus of the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface soc_mem_arbiter_if #(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);

   logic [NUM_PORTS-1:0]              req_valid;
   logic [NUM_PORTS-1:0]              req_ready;
   logic [NUM_PORTS-1:0]              req_we;
   logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata;
   logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_be;
   logic [NUM_PORTS-1:0]              rsp_valid;
   logic [DATA_WIDTH-1:0]             rsp_rdata;
   logic                              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface
`default_nettype wire

// File: rtl/soc_mem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin grant generator with rotating priority pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import soc_mem_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  wire                  clk,
   input  wire                  reset,
   input  wire [NUM_PORTS-1:0]  req_valid,
   output logic [NUM_PORTS-1:0] grant
);

   localparam logic [PTR_W1-1:0] c_nports = PTR_W1'(NUM_PORTS);

   logic [PTR_W-1:0]     r_ptr;
   logic [PTR_W-1:0]     w_ptr_next;
   logic [MAX_PORTS-1:0] w_pick;
   logic                 w_unused_pick;

   assign w_pick        = rr_pick(MAX_PORTS'(req_valid), r_ptr, c_nports);
   // No grant may leak out while the block is held in reset.
   assign grant         = reset ? '0 : w_pick[NUM_PORTS-1:0];
   assign w_unused_pick = ^w_pick;

   always_comb begin
      w_ptr_next = r_ptr;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant[i]) begin
            w_ptr_next = (i == NUM_PORTS - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptr_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : soc_mem_arbiter
//  Description : Single-port data RAM shared by NUM_PORTS requesters through a
//                round-robin arbiter, with byte enables and fixed read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_mem_arbiter
   import soc_mem_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 64,
   parameter int RD_LATENCY = 1
) (
   input wire               clk,
   input wire               reset,
   soc_mem_arbiter_if.slave bus
);

   localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int ADDR_W1    = ADDR_WIDTH + 1;
   localparam int NUM_BYTES  = DATA_WIDTH / 8;
   localparam logic [ADDR_W1-1:0] c_depth = ADDR_W1'(MEM_DEPTH);

   logic [NUM_PORTS-1:0]  w_grant;
   logic                  w_accept;
   logic                  w_we;
   logic                  w_in_range;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_ram_word;
   logic [NUM_BYTES-1:0]  w_be;
   rsp_stage_t            w_stage0;
   rsp_stage_t            r_pipe [RD_LATENCY];
   logic [DATA_WIDTH-1:0] r_mem  [MEM_DEPTH];
   logic                  w_unused_stage;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS)
   ) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req_valid (bus.req_valid),
      .grant     (w_grant)
   );

   assign bus.req_ready = w_grant;
   assign w_accept      = |w_grant;

   // Grant is one-hot, so an AND-OR select of the winning port's fields.
   always_comb begin
      w_we    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      w_be    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_grant[i]) begin
            w_we    = bus.req_we[i];
            w_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_be    = bus.req_be[i*NUM_BYTES +: NUM_BYTES];
         end
      end
   end

   assign w_in_range = {1'b0, w_addr} < c_depth;
   assign w_ram_addr = w_in_range ? w_addr : '0;
   assign w_ram_word = r_mem[w_ram_addr];

   always_ff @(posedge clk) begin
      if (w_accept && w_we && w_in_range) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (w_be[k]) begin
               r_mem[w_ram_addr][k*8 +: 8] <= w_wdata[k*8 +: 8];
            end
         end
      end
   end

   // Writes and out-of-range reads respond with zero data.
   always_comb begin
      w_stage0 = '0;
      if (w_accept) begin
         w_stage0.port = MAX_PORTS'(w_grant);
         w_stage0.err  = !w_in_range;
         if (!w_we && w_in_range) begin
            w_stage0.rdata = MAX_DATA_WIDTH'(w_ram_word);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= w_stage0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign bus.rsp_valid  = r_pipe[RD_LATENCY-1].port[NUM_PORTS-1:0];
   assign bus.rsp_rdata  = r_pipe[RD_LATENCY-1].rdata[DATA_WIDTH-1:0];
   assign bus.rsp_err    = r_pipe[RD_LATENCY-1].err;
   assign w_unused_stage = ^r_pipe[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_mem_arbiter
//  Description : Directed vector bench for soc_mem_arbiter (2 ports, depth 48,
//                read latency 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_mem_arbiter;

   localparam int NP  = 2;
   localparam int DW  = 32;
   localparam int AW  = 6;
   localparam int LAT = 3;

   typedef struct {
      int          port;
      logic        we;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;
   vec_t vecs [18];

   soc_mem_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   soc_mem_arbiter #(
      .NUM_PORTS  (NP),
      .DATA_WIDTH (DW),
      .MEM_DEPTH  (48),
      .RD_LATENCY (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int p, input logic we, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      bus.req_valid[p]           = 1'b1;
      bus.req_we[p]              = we;
      bus.req_addr[p*AW +: AW]   = a;
      bus.req_wdata[p*DW +: DW]  = d;
      bus.req_be[p*4 +: 4]       = be;
   endtask

   task automatic do_txn(input vec_t v);
      logic [1:0] oh;
      oh       = '0;
      oh[v.port] = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = '0;
      drive(v.port, v.we, v.addr, v.wdata, v.be);
      @(negedge clk);
      check("txn_ready", 64'(bus.req_ready), 64'(oh));
      @(posedge clk); #1;
      bus.req_valid = '0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k < LAT) begin
            check("txn_early_valid", 64'(bus.rsp_valid), 64'd0);
         end else begin
            check("txn_rsp_valid", 64'(bus.rsp_valid), 64'(oh));
            check("txn_rsp_rdata", 64'(bus.rsp_rdata), 64'(v.exp_rdata));
            check("txn_rsp_err",   64'(bus.rsp_err),   64'(v.exp_err));
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  exp_oh;
      logic [31:0] exp_d;
      logic [31:0] rd3 [3];
      int          cnt0;
      int          cnt1;

      n_vec = 0;
      n_bad = 0;
      vecs[0]  = '{0, 1'b1, 6'd5,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{0, 1'b0, 6'd5,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{0, 1'b1, 6'd3,  32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
      vecs[3]  = '{0, 1'b1, 6'd3,  32'h11223344, 4'h2, 32'h0,        1'b0};
      vecs[4]  = '{0, 1'b0, 6'd3,  32'h0,        4'hF, 32'hAABB33DD, 1'b0};
      vecs[5]  = '{1, 1'b1, 6'd2,  32'h01020304, 4'hF, 32'h0,        1'b0};
      vecs[6]  = '{0, 1'b1, 6'd50, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      vecs[7]  = '{1, 1'b0, 6'd50, 32'h0,        4'hF, 32'h0,        1'b1};
      vecs[8]  = '{1, 1'b0, 6'd2,  32'h0,        4'hF, 32'h01020304, 1'b0};
      vecs[9]  = '{0, 1'b1, 6'd47, 32'h12345678, 4'hF, 32'h0,        1'b0};
      vecs[10] = '{1, 1'b1, 6'd47, 32'hA5A5A5A5, 4'h9, 32'h0,        1'b0};
      vecs[11] = '{0, 1'b0, 6'd47, 32'h0,        4'hF, 32'hA53456A5, 1'b0};
      vecs[12] = '{1, 1'b0, 6'd48, 32'h0,        4'hF, 32'h0,        1'b1};
      vecs[13] = '{0, 1'b1, 6'd5,  32'h00000000, 4'h0, 32'h0,        1'b0};
      vecs[14] = '{0, 1'b1, 6'd0,  32'h0A0A0A0A, 4'hF, 32'h0,        1'b0};
      vecs[15] = '{1, 1'b1, 6'd1,  32'h1B1B1B1B, 4'hF, 32'h0,        1'b0};
      vecs[16] = '{0, 1'b0, 6'd5,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
      vecs[17] = '{1, 1'b0, 6'd1,  32'h0,        4'hF, 32'h1B1B1B1B, 1'b0};

      // Reset: both ports requesting, nothing may be granted or returned.
      reset         = 1'b1;
      bus.req_valid = 2'b11;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      repeat (2) begin
         @(negedge clk);
         check("reset_ready",     64'(bus.req_ready), 64'd0);
         check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
         check("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
         check("reset_rsp_err",   64'(bus.rsp_err),   64'd0);
      end
      @(posedge clk); #1;
      bus.req_valid = '0;
      reset         = 1'b0;

      for (int i = 0; i < 18; i++) begin
         do_txn(vecs[i]);
      end

      // Both ports stream reads for 6 cycles; pointer starts at 0.
      cnt0 = 0;
      cnt1 = 0;
      @(posedge clk); #1;
      drive(0, 1'b0, 6'd5, 32'h0, 4'hF);
      drive(1, 1'b0, 6'd3, 32'h0, 4'hF);
      for (int c = 0; c < 6 + LAT; c++) begin
         @(negedge clk);
         exp_oh = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
         check("rr_ready", 64'(bus.req_ready), 64'(exp_oh));
         if (c >= LAT) begin
            exp_oh = ((c - LAT) % 2 == 0) ? 2'b01 : 2'b10;
            exp_d  = ((c - LAT) % 2 == 0) ? 32'hDEADBEEF : 32'hAABB33DD;
         end else begin
            exp_oh = 2'b00;
            exp_d  = 32'h0;
         end
         check("rr_rsp_valid", 64'(bus.rsp_valid), 64'(exp_oh));
         check("rr_rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_d));
         if (bus.rsp_valid[0]) cnt0++;
         if (bus.rsp_valid[1]) cnt1++;
         @(posedge clk); #1;
         if (c == 5) bus.req_valid = '0;
      end
      check("rr_count_p0", 64'(cnt0), 64'd3);
      check("rr_count_p1", 64'(cnt1), 64'd3);

      // Write then immediate read of the same word.
      @(posedge clk); #1;
      drive(0, 1'b1, 6'd4, 32'h55AA55AA, 4'hF);
      @(negedge clk);
      check("raw_wr_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      drive(0, 1'b0, 6'd4, 32'h0, 4'hF);
      @(negedge clk);
      check("raw_rd_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("raw_idle_valid", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      check("raw_wr_ack_valid", 64'(bus.rsp_valid), 64'd1);
      check("raw_wr_ack_rdata", 64'(bus.rsp_rdata), 64'd0);
      @(negedge clk);
      check("raw_rd_valid", 64'(bus.rsp_valid), 64'd1);
      check("raw_rd_rdata", 64'(bus.rsp_rdata), 64'h55AA55AA);

      // Back-to-back reads of addresses 0,1,2.
      rd3[0] = 32'h0A0A0A0A;
      rd3[1] = 32'h1B1B1B1B;
      rd3[2] = 32'h01020304;
      @(posedge clk); #1;
      drive(0, 1'b0, 6'd0, 32'h0, 4'hF);
      for (int c = 0; c < 3 + LAT; c++) begin
         @(negedge clk);
         check("b2b_ready", 64'(bus.req_ready), (c < 3) ? 64'd1 : 64'd0);
         check("b2b_rsp_valid", 64'(bus.rsp_valid), (c >= LAT) ? 64'd1 : 64'd0);
         check("b2b_rsp_rdata", 64'(bus.rsp_rdata), (c >= LAT) ? 64'(rd3[c-LAT]) : 64'd0);
         @(posedge clk); #1;
         if (c < 2) begin
            bus.req_addr[0 +: AW] = AW'(c + 1);
         end else begin
            bus.req_valid = '0;
         end
      end

      // Reset while a read is in flight: its response must vanish.
      @(posedge clk); #1;
      drive(0, 1'b0, 6'd5, 32'h0, 4'hF);
      @(negedge clk);
      check("mid_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(posedge clk); #1;
      reset         = 1'b1;
      bus.req_valid = 2'b11;
      repeat (2) begin
         @(negedge clk);
         check("mid_reset_ready", 64'(bus.req_ready), 64'd0);
         check("mid_reset_rsp",   64'(bus.rsp_valid), 64'd0);
         @(posedge clk); #1;
      end
      reset         = 1'b0;
      bus.req_valid = '0;
      repeat (10) begin
         @(negedge clk);
         check("mid_after_rsp", 64'(bus.rsp_valid), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
